// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: opcode enum, flag bit positions and the
// illegal-opcode helper shared by the pipe_alu_param slice.
package pipe_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_PSA  = 4'd3,
    OP_PSB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NEGA = 4'd8,
    OP_NEGB = 4'd9,
    OP_SRL  = 4'd10,
    OP_SHL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_LDI  = 4'd13
  } func_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd14;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  function automatic logic is_illegal(
    input logic [3:0] f
  );
    return f >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU. Ports: i_a/i_b operands, i_imm
// for LDI, i_func opcode -> o_result, o_carry, o_illegal.
module alu_core
  import pipe_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [3:0]        i_func,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_illegal
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_prod;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_prod    = i_a * i_b;
  assign o_illegal = is_illegal(i_func);

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    unique case (func_e'(i_func))
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = i_a - i_b;
        // borrow out of the subtraction
        o_carry  = i_a < i_b;
      end
      OP_MUL:  o_result = w_prod;
      OP_PSA:  o_result = i_a;
      OP_PSB:  o_result = i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NEGA: o_result = '0 - i_a;
      OP_NEGB: o_result = '0 - i_b;
      OP_SRL:  o_result = {1'b0, i_a[DATA_W-1:1]};
      OP_SHL:  o_result = {i_a[DATA_W-2:0], 1'b0};
      OP_SRA:  o_result = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
      OP_LDI:  o_result = i_imm;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_alu_param.sv
// pipe_alu_param: 4-stage ALU pipe (capture/ALU/writeback/mem)
// with forwarding, flags, err pulse and registered mem read.
// Ports: clk, rst_n, in_valid, func, rs1, rs2, rd, addr, imm in;
// z, z_valid, flags{c,n,z}, err out; mem_raddr in, mem_rdata out.
module pipe_alu_param
  import pipe_alu_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NREGS     = 16,
  parameter  int MEM_DEPTH = 256,
  localparam int RA_W      = $clog2(NREGS),
  localparam int MA_W      = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        func,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic [MA_W-1:0]   addr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] z,
  output logic              z_valid,
  output logic [2:0]        flags,
  output logic              err,
  input  logic [MA_W-1:0]   mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] r_rf  [NREGS];
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [RA_W-1:0]   r_s1_rd;
  logic [3:0]        r_s1_func;
  logic [MA_W-1:0]   r_s1_addr;
  logic [DATA_W-1:0] r_s1_imm;

  logic              r_s2_ok;
  logic              r_s2_ill;
  logic [DATA_W-1:0] r_s2_z;
  logic              r_s2_c;
  logic [RA_W-1:0]   r_s2_rd;
  logic [MA_W-1:0]   r_s2_addr;

  logic [DATA_W-1:0] r_z;
  logic              r_z_valid;
  logic [2:0]        r_flags;
  logic              r_err;
  logic [MA_W-1:0]   r_s3_addr;
  logic [DATA_W-1:0] r_mem_rdata;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_ill;
  logic              w_s1_fwd;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  alu_core #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_imm    (r_s1_imm),
    .i_func   (r_s1_func),
    .o_result (w_alu_res),
    .o_carry  (w_alu_c),
    .o_illegal(w_alu_ill)
  );

  assign w_s1_fwd = r_s1_valid & ~w_alu_ill;

  // Youngest producer wins: S1 ALU output, then S2 result,
  // then the bank (S2 is being written to the bank this edge).
  always_comb begin
    w_op1 = r_rf[rs1];
    if (w_s1_fwd && r_s1_rd == rs1)
      w_op1 = w_alu_res;
    else if (r_s2_ok && r_s2_rd == rs1)
      w_op1 = r_s2_z;

    w_op2 = r_rf[rs2];
    if (w_s1_fwd && r_s1_rd == rs2)
      w_op2 = w_alu_res;
    else if (r_s2_ok && r_s2_rd == rs2)
      w_op2 = r_s2_z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_rd    <= '0;
      r_s1_func  <= '0;
      r_s1_addr  <= '0;
      r_s1_imm   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_a     <= w_op1;
      r_s1_b     <= w_op2;
      r_s1_rd    <= rd;
      r_s1_func  <= func;
      r_s1_addr  <= addr;
      r_s1_imm   <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_ok   <= 1'b0;
      r_s2_ill  <= 1'b0;
      r_s2_z    <= '0;
      r_s2_c    <= 1'b0;
      r_s2_rd   <= '0;
      r_s2_addr <= '0;
    end else begin
      r_s2_ok   <= r_s1_valid & ~w_alu_ill;
      r_s2_ill  <= r_s1_valid & w_alu_ill;
      r_s2_z    <= w_alu_res;
      r_s2_c    <= w_alu_c;
      r_s2_rd   <= r_s1_rd;
      r_s2_addr <= r_s1_addr;
    end
  end

  // z and flags hold across bubbles and illegal ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
      r_flags   <= '0;
      r_err     <= 1'b0;
      r_s3_addr <= '0;
    end else begin
      r_z_valid <= r_s2_ok;
      r_err     <= r_s2_ill;
      if (r_s2_ok) begin
        r_z             <= r_s2_z;
        r_s3_addr       <= r_s2_addr;
        r_flags[FLAG_C] <= r_s2_c;
        r_flags[FLAG_N] <= r_s2_z[DATA_W-1];
        r_flags[FLAG_Z] <= (r_s2_z == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else if (r_s2_ok) begin
      r_rf[r_s2_rd] <= r_s2_z;
    end
  end

  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (r_z_valid)
      r_mem[r_s3_addr] <= r_z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mem_rdata <= '0;
    else
      r_mem_rdata <= r_mem[mem_raddr];
  end

  assign z         = r_z;
  assign z_valid   = r_z_valid;
  assign flags     = r_flags;
  assign err       = r_err;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_pipe_alu_param.sv
// tb_pipe_alu_param: directed plus random stimulus against an
// in-order architectural model of pipe_alu_param.
module tb_pipe_alu_param;

  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  func = '0;
  logic [3:0]  rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic [3:0]  rd = '0;
  logic [7:0]  addr = '0;
  logic [15:0] imm = '0;
  logic [15:0] z;
  logic        z_valid;
  logic [2:0]  flags;
  logic        err;
  logic [7:0]  mem_raddr = '0;
  logic [15:0] mem_rdata;

  pipe_alu_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .func     (func),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .addr     (addr),
    .imm      (imm),
    .z        (z),
    .z_valid  (z_valid),
    .flags    (flags),
    .err      (err),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  bit          ov   [NC];
  bit          oe   [NC];
  logic [15:0] oz   [NC];
  logic [2:0]  ofl  [NC];
  bit          wv   [NC];
  logic [7:0]  wa   [NC];
  logic [15:0] wd   [NC];
  logic [15:0] mmod [256];
  bit          mvld [256];
  logic [15:0] regs [16];
  logic [15:0] hz = '0;
  logic [2:0]  hf = '0;
  logic [15:0] exp_rd;
  bit          rd_known;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_op(
    input  int     f,
    input  longint a,
    input  longint b,
    input  longint im,
    output longint r,
    output bit     cy,
    output bit     il
  );
    longint m = 65536;
    cy = 0;
    il = 0;
    case (f)
      0:  begin r = a + b; cy = (r >= m); end
      1:  begin r = a - b + m; cy = (a < b); end
      2:  r = a * b;
      3:  r = a;
      4:  r = b;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = m - a;
      9:  r = m - b;
      10: r = a / 2;
      11: r = a * 2;
      12: r = a / 2 + ((a >= 32768) ? 32768 : 0);
      13: r = im;
      default: begin r = 0; il = 1; end
    endcase
    r = r % m;
  endfunction

  task automatic model_edge();
    longint r;
    bit     cy;
    bit     il;
    rd_known = mvld[mem_raddr];
    exp_rd   = mmod[mem_raddr];
    if (wv[cyc]) begin
      mmod[wa[cyc]] = wd[cyc];
      mvld[wa[cyc]] = 1;
    end
    if (in_valid) begin
      ref_op(int'(func), longint'(regs[rs1]),
             longint'(regs[rs2]), longint'(imm),
             r, cy, il);
      if (il) begin
        oe[cyc+2] = 1;
      end else begin
        regs[rd]   = 16'(r);
        ov[cyc+2]  = 1;
        oz[cyc+2]  = 16'(r);
        ofl[cyc+2] = {cy, r >= 32768, r == 0};
        wv[cyc+3]  = 1;
        wa[cyc+3]  = addr;
        wd[cyc+3]  = 16'(r);
      end
    end
  endtask

  task automatic check_outs();
    if (ov[cyc]) begin
      hz = oz[cyc];
      hf = ofl[cyc];
    end
    chk("z_valid", 32'(z_valid), 32'(ov[cyc]));
    chk("err", 32'(err), 32'(oe[cyc]));
    chk("z", 32'(z), 32'(hz));
    chk("flags", 32'(flags), 32'(hf));
    if (rd_known)
      chk("mem_rdata", 32'(mem_rdata), 32'(exp_rd));
  endtask

  task automatic step(
    input bit v,
    input int f,
    input int a1,
    input int a2,
    input int d,
    input int ad,
    input int im
  );
    in_valid = v;
    func     = 4'(f);
    rs1      = 4'(a1);
    rs2      = 4'(a2);
    rd       = 4'(d);
    addr     = 8'(ad);
    imm      = 16'(im);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic bub();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_zv", 32'(z_valid), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(mem_rdata), 0);
    for (int i = cyc + 1; i < NC; i++) begin
      ov[i] = 0;
      oe[i] = 0;
      wv[i] = 0;
    end
    for (int i = 0; i < 16; i++)
      regs[i] = '0;
    hz = '0;
    hf = '0;
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    chk("rst_hold_zv", 32'(z_valid), 0);
    chk("rst_hold_rd", 32'(mem_rdata), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      regs[i] = '0;
    #1;
    do_reset();

    // LDI/LDI/ADD back to back
    mem_raddr = 8'h00;
    step(1, 13, 0, 0, 1, 'hF0, 5);
    step(1, 13, 0, 0, 2, 'hF0, 3);
    step(1, 0, 1, 2, 3, 'h10, 0);
    bub();
    bub();
    chk("add_z", 32'(z), 8);
    chk("add_zv", 32'(z_valid), 1);
    chk("add_flags", 32'(flags), 0);
    mem_raddr = 8'h10;
    bub();
    bub();
    chk("add_mem", 32'(mem_rdata), 8);

    // reset with three instructions in flight
    step(1, 13, 0, 0, 1, 'h10, 'h1234);
    step(1, 0, 1, 1, 2, 'h10, 0);
    step(1, 13, 0, 0, 3, 'h10, 7);
    do_reset();
    bub();
    bub();
    chk("rst_mem", 32'(mem_rdata), 8);
    step(1, 0, 1, 2, 4, 'hF2, 0);
    bub();
    bub();
    chk("rst_rf_z", 32'(z), 0);
    chk("rst_rf_zv", 32'(z_valid), 1);

    // SUB zero / borrow cases
    step(1, 13, 0, 0, 4, 'hF1, 1);
    bub();
    step(1, 1, 4, 4, 5, 'hF1, 0);
    bub();
    bub();
    chk("sub0_z", 32'(z), 0);
    chk("sub0_flags", 32'(flags), 32'b001);
    step(1, 1, 0, 4, 6, 'hF1, 0);
    bub();
    bub();
    chk("subb_z", 32'(z), 'hFFFF);
    chk("subb_flags", 32'(flags), 32'b110);

    // shifts of 0x8000
    step(1, 13, 0, 0, 7, 'hF2, 'h8000);
    step(1, 12, 7, 0, 8, 'hF2, 0);
    step(1, 10, 7, 0, 9, 'hF2, 0);
    step(1, 11, 7, 0, 10, 'hF2, 0);
    chk("sra_z", 32'(z), 'hC000);
    bub();
    chk("srl_z", 32'(z), 'h4000);
    bub();
    chk("shl_z", 32'(z), 0);
    chk("shl_flags", 32'(flags), 32'b001);

    // illegal opcode
    step(1, 13, 0, 0, 1, 'hF3, 5);
    bub();
    bub();
    bub();
    step(1, 14, 0, 0, 1, 'h10, 0);
    bub();
    bub();
    chk("ill_err", 32'(err), 1);
    chk("ill_zv", 32'(z_valid), 0);
    chk("ill_z", 32'(z), 5);
    step(1, 0, 1, 0, 11, 'hF4, 0);
    bub();
    bub();
    chk("ill_r1", 32'(z), 5);
    chk("ill_mem", 32'(mem_rdata), 8);

    // MUL and read-during-write
    mem_raddr = 8'h00;
    step(1, 13, 0, 0, 12, 'h20, 'h0100);
    step(1, 2, 12, 12, 13, 'h20, 0);
    bub();
    bub();
    chk("mul_z", 32'(z), 0);
    chk("mul_zv", 32'(z_valid), 1);
    mem_raddr = 8'h20;
    bub();
    chk("rdw_old", 32'(mem_rdata), 'h0100);
    bub();
    chk("rdw_new", 32'(mem_rdata), 0);

    // random traffic with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(1, 13, 0, 0, 1, 1, 'h55);
        step(1, 0, 1, 1, 2, 2, 0);
        step(1, 13, 0, 0, 3, 3, 'h77);
        do_reset();
      end
      mem_raddr = 8'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0,
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 65535)));
    end
    bub();
    bub();
    bub();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
